// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit
//  Purpose  : Multi-cycle control sequencer for the 16-bit, 4-bit-opcode CPU.
//             Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and
//             drives PC/IR strobes, RegFile/memory enables and datapath
//             selects. Supports variable-latency MUL, memory ready handshake
//             with optional timeout, and a resumable HALT.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int INST_W      = 16,
    parameter int ALUOP_W     = 4,
    parameter int MUL_LAT     = 2,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INST_W-1:0]  inst,
    input  logic               n,
    input  logic               z,
    input  logic               p,
    input  logic               mem_ready,
    input  logic               resume,
    output logic               ir_we,
    output logic               pc_we,
    output logic               pc_sel,
    output logic               alu_src2_sel,
    output logic               write_data_sel,
    output logic               reg_we,
    output logic               mem_re,
    output logic               mem_we,
    output logic               ext_sel,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               halted,
    output logic               err,
    output logic [2:0]         state
);

    // State encodings are visible on the debug port, so they are fixed values.
    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;

    localparam logic [3:0] c_OP_MUL  = 4'b0110;
    localparam logic [3:0] c_OP_ST   = 4'b1001;
    localparam logic [3:0] c_OP_LD   = 4'b1010;
    localparam logic [3:0] c_OP_BRZ  = 4'b1011;
    localparam logic [3:0] c_OP_BRN  = 4'b1100;
    localparam logic [3:0] c_OP_BRP  = 4'b1101;
    localparam logic [3:0] c_OP_JMP  = 4'b1110;
    localparam logic [3:0] c_OP_HALT = 4'b1111;

    // One shared counter serves both the MUL latency and the MEM timeout;
    // it only ever needs to reach max(MUL_LAT, MEM_TIMEOUT) - 1.
    localparam int c_CNT_MAX = (MUL_LAT > MEM_TIMEOUT) ? MUL_LAT : MEM_TIMEOUT;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam bit c_TO_EN   = (MEM_TIMEOUT > 0);

    localparam logic [c_CNT_W-1:0] c_MUL_LAST = c_CNT_W'(MUL_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_MEM_LAST = c_CNT_W'(c_TO_EN ? MEM_TIMEOUT - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_err_nxt;

    logic w_ir_we, w_pc_we, w_pc_sel, w_reg_we, w_mem_re, w_mem_we, w_halted;
    logic w_src2, w_wds, w_ext;
    logic [3:0] w_alu;

    logic [3:0] w_opcode;
    logic       w_imm;
    logic       w_is_st;
    logic       w_is_mem;
    logic       w_unused_ok;

    assign w_opcode    = inst[INST_W-1 -: 4];
    assign w_imm       = inst[5];
    assign w_is_st     = (w_opcode == c_OP_ST);
    assign w_is_mem    = (w_opcode == c_OP_ST) || (w_opcode == c_OP_LD);
    assign w_unused_ok = ^{inst[INST_W-5:6], inst[4:0]};

    // State, counter and sticky error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FETCH;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Sequencing: next state, counter, error flag and control strobes.
    always_comb begin
        w_state_nxt = c_ST_FETCH;
        w_cnt_nxt   = '0;
        w_err_nxt   = r_err;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_sel    = 1'b0;
        w_reg_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_we    = 1'b0;
        w_halted    = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                w_ir_we     = 1'b1;
                w_state_nxt = c_ST_DECODE;
            end
            c_ST_DECODE: begin
                case (w_opcode)
                    c_OP_HALT: w_state_nxt = c_ST_HALT;
                    c_OP_BRZ: begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = z;
                    end
                    c_OP_BRN: begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = n;
                    end
                    c_OP_BRP: begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = p;
                    end
                    c_OP_JMP: begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = 1'b1;
                    end
                    default: w_state_nxt = c_ST_EXEC;
                endcase
            end
            c_ST_EXEC: begin
                if ((w_opcode == c_OP_MUL) && (r_cnt != c_MUL_LAST)) begin
                    w_state_nxt = c_ST_EXEC;
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end else if (w_is_mem) begin
                    w_state_nxt = c_ST_MEM;
                end else begin
                    w_state_nxt = c_ST_WB;
                end
            end
            c_ST_MEM: begin
                w_mem_we = w_is_st;
                w_mem_re = ~w_is_st;
                // A ready arriving on the final timeout cycle still completes.
                if (mem_ready) begin
                    if (w_is_st) begin
                        w_pc_we     = 1'b1;
                        w_state_nxt = c_ST_FETCH;
                    end else begin
                        w_state_nxt = c_ST_WB;
                    end
                end else if (c_TO_EN && (r_cnt == c_MEM_LAST)) begin
                    w_state_nxt = c_ST_HALT;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_state_nxt = c_ST_MEM;
                    w_cnt_nxt   = c_TO_EN ? (r_cnt + c_CNT_ONE) : '0;
                end
            end
            c_ST_WB: begin
                w_reg_we = 1'b1;
                w_pc_we  = 1'b1;
            end
            c_ST_HALT: begin
                w_halted = 1'b1;
                if (resume) begin
                    w_pc_we   = 1'b1;
                    w_err_nxt = 1'b0;
                end else begin
                    w_state_nxt = c_ST_HALT;
                end
            end
            default: w_state_nxt = c_ST_FETCH;
        endcase
    end

    // Datapath decode, held for the whole instruction after FETCH.
    always_comb begin
        w_alu  = 4'b0000;
        w_src2 = 1'b0;
        w_wds  = 1'b0;
        w_ext  = 1'b0;
        if ((r_state == c_ST_DECODE) || (r_state == c_ST_EXEC) ||
            (r_state == c_ST_MEM) || (r_state == c_ST_WB)) begin
            case (w_opcode)
                4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110: begin
                    w_alu  = w_opcode;
                    w_src2 = w_imm;
                    w_ext  = w_imm;
                end
                4'b0001, 4'b0111, 4'b1000: w_alu = w_opcode;
                c_OP_ST: begin
                    w_src2 = 1'b1;
                    w_ext  = 1'b1;
                end
                c_OP_LD: begin
                    w_src2 = 1'b1;
                    w_ext  = 1'b1;
                    w_wds  = 1'b1;
                end
                default: w_ext = 1'b1;
            endcase
        end
    end

    // Every output is forced low while reset is held so no partial write escapes.
    assign ir_we          = w_ir_we  & ~rst;
    assign pc_we          = w_pc_we  & ~rst;
    assign pc_sel         = w_pc_sel & ~rst;
    assign reg_we         = w_reg_we & ~rst;
    assign mem_re         = w_mem_re & ~rst;
    assign mem_we         = w_mem_we & ~rst;
    assign halted         = w_halted & ~rst;
    assign alu_src2_sel   = w_src2   & ~rst;
    assign write_data_sel = w_wds    & ~rst;
    assign ext_sel        = w_ext    & ~rst;
    assign err            = r_err    & ~rst;
    assign alu_op         = rst ? '0 : ALUOP_W'(w_alu);
    assign state          = rst ? 3'd0 : r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control_unit
//  Purpose  : Scoreboard bench for multicycle_control_unit. Random instruction
//             stream with random memory latency and HALT resume delay; a
//             per-instruction reference model predicts the retire signature.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam int MUL_LAT     = 3;
    localparam int MEM_TIMEOUT = 4;
    localparam int N_INSTR     = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inst;
    logic        n, z, p, mem_ready, resume;
    logic        ir_we, pc_we, pc_sel, alu_src2_sel, write_data_sel, reg_we;
    logic        mem_re, mem_we, ext_sel, halted, err;
    logic [3:0]  alu_op;
    logic [2:0]  state;

    multicycle_control_unit #(
        .INST_W(16), .ALUOP_W(4), .MUL_LAT(MUL_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .inst(inst), .n(n), .z(z), .p(p),
        .mem_ready(mem_ready), .resume(resume),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_src2_sel(alu_src2_sel), .write_data_sel(write_data_sel),
        .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .ext_sel(ext_sel),
        .alu_op(alu_op), .halted(halted), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    // Signature an instruction leaves from its FETCH up to its PC update.
    typedef struct {
        int         cycles;
        int         regs;
        int         mre;
        int         mwe;
        int         halts;
        bit         pc_sel;
        bit         err;
        logic [3:0] alu;
        bit         src2;
        bit         ext;
        bit         wds;
    } exp_t;

    exp_t q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   issued  = 0;
    int   retired = 0;
    bit   drv_en  = 0;
    bit   mon_en  = 0;
    bit   drv_done = 0;
    int   cur_k, cur_d;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int outs_vec();
        return int'({ir_we, pc_we, pc_sel, alu_src2_sel, write_data_sel, reg_we,
                     mem_re, mem_we, ext_sel, halted, err, alu_op, state});
    endfunction

    // Reference model: timing and retire-cycle controls from the ISA rules.
    function automatic exp_t model(input logic [15:0] ins, input bit fn, input bit fz,
                                   input bit fp, input int k, input int d);
        exp_t e;
        logic [3:0] op;
        bit imm;
        bit timed;
        e = '{default: 0};
        op  = ins[15:12];
        imm = ins[5];
        if (op == 4'd15) begin
            e.cycles = 2 + d + 1;
            e.halts  = d + 1;
        end else if (op >= 4'd11) begin
            e.cycles = 2;
            e.ext    = 1;
            case (op)
                4'd11:   e.pc_sel = fz;
                4'd12:   e.pc_sel = fn;
                4'd13:   e.pc_sel = fp;
                default: e.pc_sel = 1;
            endcase
        end else if (op == 4'd9 || op == 4'd10) begin
            timed = (MEM_TIMEOUT > 0) && (k > MEM_TIMEOUT);
            if (timed) begin
                e.cycles = 3 + MEM_TIMEOUT + d + 1;
                e.halts  = d + 1;
                e.err    = 1;
                if (op == 4'd9) e.mwe = MEM_TIMEOUT; else e.mre = MEM_TIMEOUT;
            end else begin
                e.src2 = 1;
                e.ext  = 1;
                if (op == 4'd9) begin
                    e.cycles = 3 + k;
                    e.mwe    = k;
                end else begin
                    e.cycles = 4 + k;
                    e.mre    = k;
                    e.regs   = 1;
                    e.wds    = 1;
                end
            end
        end else begin
            e.cycles = (op == 4'd6) ? 3 + MUL_LAT : 4;
            e.regs   = 1;
            e.alu    = op;
            if (op <= 4'd6 && op != 4'd1) begin
                e.src2 = imm;
                e.ext  = imm;
            end
        end
        return e;
    endfunction

    // Driver: new instruction at every FETCH, plus reactive ready/resume.
    initial begin
        int memcnt = 0;
        int hcnt   = 0;
        forever begin
            @(negedge clk);
            if (drv_en) begin
                if (ir_we) begin
                    memcnt = 0;
                    hcnt   = 0;
                    if (issued < N_INSTR) begin
                        inst  = 16'($urandom);
                        inst[15:12] = 4'($urandom_range(0, 15));
                        n     = 1'($urandom);
                        z     = 1'($urandom);
                        p     = 1'($urandom);
                        cur_k = $urandom_range(1, 6);
                        cur_d = $urandom_range(0, 3);
                        q.push_back(model(inst, n, z, p, cur_k, cur_d));
                        issued++;
                    end else begin
                        inst     = 16'hF000;
                        drv_done = 1;
                    end
                end
                if (mem_re || mem_we) begin
                    memcnt++;
                    mem_ready = (memcnt == cur_k);
                end else begin
                    mem_ready = drv_done ? 1'b0 : 1'($urandom);
                end
                if (halted) begin
                    hcnt++;
                    resume = !drv_done && (hcnt == cur_d + 1);
                end else begin
                    resume = drv_done ? 1'b0 : 1'($urandom);
                end
            end
        end
    end

    // Monitor: accumulate one instruction's activity, compare at its PC update.
    initial begin
        bit   active = 0;
        int   cyc = 0, regs = 0, mre = 0, mwe = 0, hlt = 0;
        bit   errs = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (ir_we) begin
                    chk("retire_before_next_fetch", int'(active), 0);
                    chk("ir_we_exclusive", int'(pc_we | reg_we), 0);
                    active = 1;
                    cyc = 0; regs = 0; mre = 0; mwe = 0; hlt = 0; errs = 0;
                end
                if (active) begin
                    cyc++;
                    regs += int'(reg_we);
                    mre  += int'(mem_re);
                    mwe  += int'(mem_we);
                    hlt  += int'(halted);
                    errs |= err;
                    if (pc_we) begin
                        if (q.size() == 0) begin
                            chk("scoreboard_nonempty", 0, 1);
                        end else begin
                            e = q.pop_front();
                            chk("cycles", cyc, e.cycles);
                            chk("pc_sel", int'(pc_sel), int'(e.pc_sel));
                            chk("reg_we_count", regs, e.regs);
                            chk("mem_re_count", mre, e.mre);
                            chk("mem_we_count", mwe, e.mwe);
                            chk("halted_count", hlt, e.halts);
                            chk("err_seen", int'(errs), int'(e.err));
                            chk("alu_op", int'(alu_op), int'(e.alu));
                            chk("alu_src2_sel", int'(alu_src2_sel), int'(e.src2));
                            chk("ext_sel", int'(ext_sel), int'(e.ext));
                            chk("write_data_sel", int'(write_data_sel), int'(e.wds));
                        end
                        active = 0;
                        retired++;
                    end
                end else if (pc_we) begin
                    chk("pc_we_without_instr", int'(pc_we), 0);
                end
            end
        end
    end

    // Directed reset checks, then the random scoreboard run.
    initial begin
        bit done;
        rst = 1'b1; inst = 16'h0000; n = 0; z = 0; p = 0; mem_ready = 0; resume = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs_vec(), 0);
        inst = 16'hF000; resume = 1; mem_ready = 1;
        #1;
        chk("reset_outputs_inputs_busy", outs_vec(), 0);
        inst = 16'h0000; resume = 0; mem_ready = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post_reset_state", int'(state), 0);
        chk("post_reset_ir_we", int'(ir_we), 1);
        chk("post_reset_err", int'(err), 0);
        inst = 16'h2283;
        @(posedge clk); #1;
        chk("sub_decode_state", int'(state), 1);
        @(posedge clk); #1;
        chk("sub_exec_state", int'(state), 2);
        chk("sub_exec_alu_op", int'(alu_op), 2);
        rst = 1'b1;
        #1;
        chk("midreset_outputs", outs_vec(), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midreset_fetch_state", int'(state), 0);
        chk("midreset_no_reg_we", int'(reg_we), 0);
        drv_en = 1;
        mon_en = 1;

        done = 0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            if (retired >= N_INSTR) begin
                done = 1;
                break;
            end
        end
        chk("run_completed_in_budget", int'(done), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("retired_count", retired, N_INSTR);
        chk("scoreboard_drained", q.size(), 0);
        chk("final_halted", int'(halted), 1);
        chk("final_state", int'(state), 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
